core_run_ctrl: RTL and testbench

Parametrised program-load and run controller for the `core` under simulation or FPGA bring-up. It streams a program into the core's instruction memory through a valid/ready port and holds the core in reset until loading completes. It then releases the core, counts cycles, and stops the run on a halt instruction or a cycle budget. It replaces hand-wired instruction-ROM assigns and fixed clock toggling with a reusable, self-terminating harness.

---
 rtl/cpu_sim_pkg.sv | 14 +
 rtl/core_run_ctrl.sv | 141 ++++++++++++++
 tb/tb_core_run_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_sim_pkg.sv
// rtl/cpu_sim_pkg.sv - shared run-controller state encoding and default halt word
package cpu_sim_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } run_state_t;

   // ECALL ends a simulated program
   localparam logic [31:0] DEFAULT_HALT_INSN = 32'h0000_0073;

endpackage

// File: rtl/core_run_ctrl.sv
// rtl/core_run_ctrl.sv - program-load and run controller holding the core in reset until loaded
module core_run_ctrl
   import cpu_sim_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned IMEM_DEPTH = 256,
   parameter int unsigned MAX_CYCLES = 1024,
   parameter logic [31:0] HALT_INSN  = DEFAULT_HALT_INSN,
   localparam int unsigned AW        = $clog2(IMEM_DEPTH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            abort,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [31:0]     ld_data,
   input  logic            ld_last,
   output logic            imem_we,
   output logic [AW-1:0]   imem_addr,
   output logic [31:0]     imem_wdata,
   output logic            core_reset,
   input  logic [XLEN-1:0] core_pc,
   input  logic [31:0]     core_inst,
   output logic            busy,
   output logic            done,
   output logic            timeout,
   output logic            load_ovf,
   output logic [XLEN-1:0] halt_pc,
   output logic [31:0]     cycle_count
);

   localparam logic [AW-1:0] LAST_ADDR  = AW'(IMEM_DEPTH - 1);
   localparam logic [31:0]   LAST_CYCLE = 32'(MAX_CYCLES - 1);

   run_state_t      state_q,      state_d;
   logic [AW-1:0]   addr_q,       addr_d;
   logic [31:0]     cycle_q,      cycle_d;
   logic            done_q,       done_d;
   logic            timeout_q,    timeout_d;
   logic            load_ovf_q,   load_ovf_d;
   logic [XLEN-1:0] halt_pc_q,    halt_pc_d;
   logic            core_reset_q, core_reset_d;
   logic            beat;

   // ld_ready depends on state only, so a beat is just valid while loading
   assign beat = (state_q == LOAD) && ld_valid;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cycle_d    = cycle_q;
      done_d     = done_q;
      timeout_d  = timeout_q;
      load_ovf_d = load_ovf_q;
      halt_pc_d  = halt_pc_q;
      if (abort) begin
         state_d    = IDLE;
         done_d     = 1'b0;
         timeout_d  = 1'b0;
         load_ovf_d = 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_d    = LOAD;
                  addr_d     = '0;
                  cycle_d    = '0;
                  done_d     = 1'b0;
                  timeout_d  = 1'b0;
                  load_ovf_d = 1'b0;
                  halt_pc_d  = '0;
               end
            end
            LOAD: begin
               if (beat) begin
                  if (ld_last) begin
                     state_d = RUN;
                  end else if (addr_q == LAST_ADDR) begin
                     state_d    = RUN;
                     load_ovf_d = 1'b1;
                  end
                  if (addr_q != LAST_ADDR) begin
                     addr_d = addr_q + 1'b1;
                  end
               end
            end
            RUN: begin
               cycle_d = cycle_q + 32'd1;
               // halt takes precedence over an expiring budget
               if (core_inst == HALT_INSN) begin
                  state_d   = DONE;
                  done_d    = 1'b1;
                  halt_pc_d = core_pc;
               end else if (cycle_q == LAST_CYCLE) begin
                  state_d   = DONE;
                  done_d    = 1'b1;
                  timeout_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      core_reset_d = (state_d != RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         cycle_q      <= '0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
         load_ovf_q   <= 1'b0;
         halt_pc_q    <= '0;
         core_reset_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         cycle_q      <= cycle_d;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
         load_ovf_q   <= load_ovf_d;
         halt_pc_q    <= halt_pc_d;
         core_reset_q <= core_reset_d;
      end
   end

   assign ld_ready    = (state_q == LOAD);
   assign imem_we     = beat;
   assign imem_addr   = addr_q;
   assign imem_wdata  = beat ? ld_data : 32'd0;
   assign core_reset  = core_reset_q;
   assign busy        = (state_q == LOAD) || (state_q == RUN);
   assign done        = done_q;
   assign timeout     = timeout_q;
   assign load_ovf    = load_ovf_q;
   assign halt_pc     = halt_pc_q;
   assign cycle_count = cycle_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb/tb_core_run_ctrl.sv - directed bench for core_run_ctrl with small memory and budget
module tb_core_run_ctrl;
   import cpu_sim_pkg::*;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned MAXC  = 8;
   localparam int unsigned AW    = 2;
   localparam logic [31:0] ADD   = 32'h0020_80B3;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] HALT  = 32'h0000_0073;

   logic            clk = 1'b0;
   logic            reset, start, abort, ld_valid, ld_last;
   logic            ld_ready, imem_we, core_reset, busy, done, timeout, load_ovf;
   logic [31:0]     ld_data, imem_wdata, core_inst, cycle_count;
   logic [AW-1:0]   imem_addr;
   logic [XLEN-1:0] core_pc, halt_pc;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];

   core_run_ctrl #(
      .XLEN(XLEN), .IMEM_DEPTH(DEPTH), .MAX_CYCLES(MAXC), .HALT_INSN(HALT)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_reset(core_reset), .core_pc(core_pc), .core_inst(core_inst),
      .busy(busy), .done(done), .timeout(timeout), .load_ovf(load_ovf),
      .halt_pc(halt_pc), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (imem_we) begin
         wr_addr.push_back(32'(imem_addr));
         wr_data.push_back(imem_wdata);
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
   endtask

   initial begin
      int n;
      reset = 1'b1; start = 1'b0; abort = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
      ld_data = '0; core_inst = NOP; core_pc = '0;
      tick(); tick();
      check_eq("rst_core_reset", core_reset, 1);
      check_eq("rst_ld_ready", ld_ready, 0);
      check_eq("rst_imem_we", imem_we, 0);
      check_eq("rst_imem_addr", imem_addr, 0);
      check_eq("rst_imem_wdata", imem_wdata, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done_to_ovf", {done, timeout, load_ovf}, 0);
      check_eq("rst_halt_pc", halt_pc, 0);
      check_eq("rst_cycle_count", cycle_count, 0);
      reset = 1'b0;

      // load 3 ADD words, halt fetched at RUN count 3
      clear_log();
      start = 1'b1; tick(); start = 1'b0;
      check_eq("t1_ld_ready", ld_ready, 1);
      check_eq("t1_busy", busy, 1);
      for (int i = 0; i < 3; i++) begin
         ld_valid = 1'b1; ld_data = ADD; ld_last = (i == 2);
         tick();
      end
      ld_valid = 1'b0; ld_last = 1'b0;
      check_eq("t1_core_reset_run", core_reset, 0);
      check_eq("t1_ld_ready_run", ld_ready, 0);
      check_eq("t1_nwrites", wr_addr.size(), 3);
      for (int i = 0; i < 3; i++) begin
         check_eq($sformatf("t1_waddr%0d", i), wr_addr[i], i);
         check_eq($sformatf("t1_wdata%0d", i), wr_data[i], ADD);
      end
      check_eq("t1_count0", cycle_count, 0);
      for (int k = 0; k < 4; k++) begin
         core_pc = 32'h100 + 32'(4 * k);
         core_inst = (k == 3) ? HALT : NOP;
         tick();
      end
      core_inst = NOP;
      check_eq("t1_done", done, 1);
      check_eq("t1_timeout", timeout, 0);
      check_eq("t1_count", cycle_count, 4);
      check_eq("t1_halt_pc", halt_pc, 32'h10C);
      check_eq("t1_core_reset_done", core_reset, 1);
      check_eq("t1_busy_done", busy, 0);

      // budget expiry with no halt, started from DONE
      start = 1'b1; tick(); start = 1'b0;
      check_eq("t2_done_cleared", done, 0);
      ld_valid = 1'b1; ld_data = ADD; ld_last = 1'b1; tick();
      ld_valid = 1'b0; ld_last = 1'b0;
      n = 0;
      for (int g = 0; g < 20 && !done; g++) begin
         if (!core_reset) n++;
         tick();
      end
      check_eq("t2_run_cycles", n, MAXC);
      check_eq("t2_done", done, 1);
      check_eq("t2_timeout", timeout, 1);
      check_eq("t2_count", cycle_count, MAXC);
      check_eq("t2_core_reset", core_reset, 1);

      // overflow: 6 words into a 4-word memory, no last
      clear_log();
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         ld_valid = 1'b1; ld_data = 32'hA0 + 32'(i); ld_last = 1'b0;
         tick();
      end
      ld_valid = 1'b0;
      check_eq("t3_nwrites", wr_addr.size(), 4);
      check_eq("t3_last_addr", wr_addr[3], 3);
      check_eq("t3_last_data", wr_data[3], 32'hA3);
      check_eq("t3_load_ovf", load_ovf, 1);
      check_eq("t3_ld_ready", ld_ready, 0);
      check_eq("t3_core_reset_run", core_reset, 0);
      check_eq("t3_count", cycle_count, 2);
      abort = 1'b1; tick(); abort = 1'b0;
      check_eq("t3_abort_idle", {busy, core_reset, done, load_ovf}, 4'b0100);

      // ld_valid pattern 1,0,1,1 with last on the 3rd beat
      clear_log();
      start = 1'b1; tick(); start = 1'b0;
      ld_valid = 1'b1; ld_data = 32'h11; ld_last = 1'b0; tick();
      ld_valid = 1'b0; #1;
      check_eq("t4_idle_no_we", imem_we, 0);
      tick();
      ld_valid = 1'b1; ld_data = 32'h22; tick();
      ld_valid = 1'b1; ld_data = 32'h33; ld_last = 1'b1; tick();
      ld_valid = 1'b0; ld_last = 1'b0;
      check_eq("t4_nwrites", wr_addr.size(), 3);
      check_eq("t4_addrs", {wr_addr[0][1:0], wr_addr[1][1:0], wr_addr[2][1:0]}, 6'b00_01_10);
      check_eq("t4_data2", wr_data[2], 32'h33);
      check_eq("t4_in_run", core_reset, 0);

      // abort at RUN count 5 beats a simultaneous halt and start
      for (int k = 0; k < 5; k++) tick();
      check_eq("t5_count5", cycle_count, 5);
      abort = 1'b1; start = 1'b1; core_inst = HALT; tick();
      abort = 1'b0; start = 1'b0; core_inst = NOP;
      check_eq("t5_busy", busy, 0);
      check_eq("t5_core_reset", core_reset, 1);
      check_eq("t5_done", done, 0);
      check_eq("t5_ld_ready", ld_ready, 0);
      start = 1'b1; tick(); start = 1'b0;
      ld_valid = 1'b1; ld_data = 32'h55; ld_last = 1'b1; #1;
      check_eq("t5_reload_addr", imem_addr, 0);
      check_eq("t5_reload_we", imem_we, 1);
      tick();
      ld_valid = 1'b0; ld_last = 1'b0;

      // halt coincides with the final budget cycle
      for (int k = 0; k < 7; k++) tick();
      check_eq("t6_count7", cycle_count, MAXC - 1);
      core_pc = 32'h2000; core_inst = HALT; tick();
      core_inst = NOP;
      check_eq("t6_done", done, 1);
      check_eq("t6_timeout", timeout, 0);
      check_eq("t6_count", cycle_count, MAXC);
      check_eq("t6_halt_pc", halt_pc, 32'h2000);
      start = 1'b1; tick(); start = 1'b0;
      check_eq("t6_cleared", {done, timeout, load_ovf}, 0);
      check_eq("t6_count_clr", cycle_count, 0);
      check_eq("t6_halt_pc_clr", halt_pc, 0);
      check_eq("t6_load", {busy, ld_ready, core_reset}, 3'b111);
      check_eq("t6_addr_clr", imem_addr, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
